// File: rtl/cnn_pkg.sv
// ============================================================================
// Module      : cnn_pkg
// Description : Shared types and saturating-arithmetic helpers for the CNN
//               fully-connected classifier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cnn_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCUM  = 3'd1,
        DRAIN  = 3'd2,
        ARGMAX = 3'd3,
        DONE   = 3'd4
    } fc_state_t;

    localparam int ACC_WIDTH_DEFAULT = 48;

    // Largest and smallest two's-complement values of a w-bit accumulator (w <= 64).
    function automatic logic signed [63:0] acc_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] acc_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int                 w
    );
        logic signed [64:0] s;
        logic signed [64:0] hi;
        logic signed [64:0] lo;
        s  = {a[63], a} + {b[63], b};
        hi = {1'b0, acc_max(w)};
        lo = {1'b1, acc_min(w)};
        if (s > hi) begin
            return hi[63:0];
        end else if (s < lo) begin
            return lo[63:0];
        end
        return s[63:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/fc_weight_rom.sv
// ============================================================================
// Module      : fc_weight_rom
// Description : Synchronous-read weight ROM, one word per input feature,
//               word i = {w[N_OUT-1][i], ..., w[0][i]}; 1-cycle read latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fc_weight_rom #(
    parameter int                       DEPTH      = 4,
    parameter int                       WIDTH      = 16,
    parameter int                       ADDR_WIDTH = 2,
    parameter logic [DEPTH*WIDTH-1:0]   INIT       = '0
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [WIDTH-1:0]      o_data
);

    always_ff @(posedge clk) begin
        o_data <= INIT[int'(i_addr) * WIDTH +: WIDTH];
    end

endmodule

`default_nettype wire

// File: rtl/fc_classifier.sv
// ============================================================================
// Module      : fc_classifier
// Description : FC output layer: streams pooled features through N_OUT
//               saturating MACs, then emits argmax class and winning score.
//               Macro FC_BIAS_EN: accumulators start from BIAS_INIT, else 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fc_classifier
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH   = 20,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ACC_WIDTH    = ACC_WIDTH_DEFAULT,
    parameter int N_IN         = 57600,
    parameter int N_OUT        = 2,
    parameter logic [N_IN*N_OUT*WEIGHT_WIDTH-1:0] WEIGHT_INIT = '0
`ifdef FC_BIAS_EN
    ,
    parameter logic [N_OUT*ACC_WIDTH-1:0] BIAS_INIT = '0
`endif
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ce,
    input  logic signed [DATA_WIDTH-1:0]  data_in,
    input  logic                          end_in,
    output logic                          busy,
    output logic                          result_valid,
    output logic [$clog2(N_OUT)-1:0]      class_id,
    output logic signed [ACC_WIDTH-1:0]   score,
    output logic                          len_err,
    output logic                          drop_err
);

    localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int CW = $clog2(N_OUT);
    localparam int PW = DATA_WIDTH + WEIGHT_WIDTH;
    localparam int RW = N_OUT * WEIGHT_WIDTH;

    fc_state_t                     r_state;
    logic [IW-1:0]                 r_idx;
    logic [CW-1:0]                 r_j;
    logic                          r_v1;
    logic                          r_v2;
    logic signed [DATA_WIDTH-1:0]  r_d1;
    logic signed [DATA_WIDTH-1:0]  r_d2;
    logic [RW-1:0]                 r_w2;
    logic signed [ACC_WIDTH-1:0]   r_acc [N_OUT];
    logic signed [ACC_WIDTH-1:0]   r_best_val;
    logic [CW-1:0]                 r_best_idx;

    logic [RW-1:0]                 w_rom;
    logic                          w_last;
    logic signed [PW-1:0]          w_prod [N_OUT];
    logic signed [ACC_WIDTH-1:0]   w_sum  [N_OUT];
    logic signed [ACC_WIDTH-1:0]   w_init [N_OUT];

    fc_weight_rom #(
        .DEPTH      (N_IN),
        .WIDTH      (RW),
        .ADDR_WIDTH (IW),
        .INIT       (WEIGHT_INIT)
    ) u_rom (
        .clk    (clk),
        .i_addr (r_idx),
        .o_data (w_rom)
    );

    assign busy   = (r_state != IDLE);
    assign w_last = end_in || (r_idx == IW'(N_IN - 1));

    always_comb begin
        for (int j = 0; j < N_OUT; j++) begin
            w_prod[j] = $signed(r_w2[j*WEIGHT_WIDTH +: WEIGHT_WIDTH]) * r_d2;
            w_sum[j]  = ACC_WIDTH'(sat_add(64'(r_acc[j]), 64'(w_prod[j]), ACC_WIDTH));
`ifdef FC_BIAS_EN
            w_init[j] = BIAS_INIT[j*ACC_WIDTH +: ACC_WIDTH];
`else
            w_init[j] = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_j          <= '0;
            r_v1         <= 1'b0;
            r_v2         <= 1'b0;
            r_d1         <= '0;
            r_d2         <= '0;
            r_w2         <= '0;
            for (int j = 0; j < N_OUT; j++) begin
                r_acc[j] <= w_init[j];
            end
            r_best_val   <= '0;
            r_best_idx   <= '0;
            result_valid <= 1'b0;
            class_id     <= '0;
            score        <= '0;
            len_err      <= 1'b0;
            drop_err     <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            r_v1         <= 1'b0;
            r_v2         <= r_v1;
            r_d2         <= r_d1;
            r_w2         <= w_rom;
            if (r_v2) begin
                for (int j = 0; j < N_OUT; j++) begin
                    r_acc[j] <= w_sum[j];
                end
            end

            case (r_state)
                IDLE, ACCUM: begin
                    if (ce) begin
                        r_v1 <= 1'b1;
                        r_d1 <= data_in;
                        if (w_last) begin
                            r_state <= DRAIN;
                            r_idx   <= '0;
                            r_j     <= '0;
                            if (end_in && (r_idx != IW'(N_IN - 1))) begin
                                len_err <= 1'b1;
                            end
                        end else begin
                            r_state <= ACCUM;
                            r_idx   <= r_idx + IW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (ce) begin
                        drop_err <= 1'b1;
                    end
                    // Two cycles let the last feature clear the ROM and MAC stages.
                    if (r_j == CW'(1)) begin
                        r_state <= ARGMAX;
                        r_j     <= '0;
                    end else begin
                        r_j     <= r_j + CW'(1);
                    end
                end
                ARGMAX: begin
                    if (ce) begin
                        drop_err <= 1'b1;
                    end
                    if ((r_j == '0) || (r_acc[r_j] > r_best_val)) begin
                        r_best_val <= r_acc[r_j];
                        r_best_idx <= r_j;
                    end
                    if (r_j == CW'(N_OUT - 1)) begin
                        r_state <= DONE;
                    end else begin
                        r_j     <= r_j + CW'(1);
                    end
                end
                DONE: begin
                    if (ce) begin
                        drop_err <= 1'b1;
                    end
                    result_valid <= 1'b1;
                    class_id     <= r_best_idx;
                    score        <= r_best_val;
                    for (int j = 0; j < N_OUT; j++) begin
                        r_acc[j] <= w_init[j];
                    end
                    r_idx   <= '0;
                    r_j     <= '0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fc_classifier.sv
// ============================================================================
// Module      : tb_fc_classifier
// Description : Self-checking bench for fc_classifier (N_IN=4, N_OUT=2) plus a
//               narrow-accumulator instance exercising saturation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fc_classifier;

    localparam int DW  = 20;
    localparam int WW  = 8;
    localparam int AW  = 48;
    localparam int SAW = 24;
    localparam int NI  = 4;
    localparam int NO  = 2;
    localparam logic [NI*NO*WW-1:0] WINIT = 64'h0104_0203_0302_0401;
    localparam logic [NI*NO*WW-1:0] SINIT = {8{8'h7F}};
`ifdef FC_BIAS_EN
    localparam logic [NO*AW-1:0]    BINIT = {-48'sd10, 48'sd10};
`endif

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  ce, end_in, s_ce, s_end_in;
    logic signed [DW-1:0]  data_in, s_data_in;
    logic                  busy, result_valid, len_err, drop_err;
    logic                  s_busy, s_result_valid, s_len_err, s_drop_err;
    logic [0:0]            class_id, s_class_id;
    logic signed [AW-1:0]  score;
    logic signed [SAW-1:0] s_score;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fc_classifier #(
        .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .ACC_WIDTH(AW), .N_IN(NI), .N_OUT(NO),
        .WEIGHT_INIT(WINIT)
`ifdef FC_BIAS_EN
        , .BIAS_INIT(BINIT)
`endif
    ) dut (
        .clk(clk), .reset(reset), .ce(ce), .data_in(data_in), .end_in(end_in),
        .busy(busy), .result_valid(result_valid), .class_id(class_id),
        .score(score), .len_err(len_err), .drop_err(drop_err)
    );

    fc_classifier #(
        .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .ACC_WIDTH(SAW), .N_IN(NI), .N_OUT(NO),
        .WEIGHT_INIT(SINIT)
    ) dut_sat (
        .clk(clk), .reset(reset), .ce(s_ce), .data_in(s_data_in), .end_in(s_end_in),
        .busy(s_busy), .result_valid(s_result_valid), .class_id(s_class_id),
        .score(s_score), .len_err(s_len_err), .drop_err(s_drop_err)
    );

    // Reference: per-class dot product with clamping after every add, then argmax (ties -> lowest).
    function automatic void model(input bit sat, input longint d[$], output int cls, output longint sc);
        longint acc [NO];
        longint hi, lo, w;
        int aw;
        aw = sat ? SAW : AW;
        hi = (longint'(1) <<< (aw - 1)) - 1;
        lo = -(longint'(1) <<< (aw - 1));
        for (int j = 0; j < NO; j++) acc[j] = 0;
`ifdef FC_BIAS_EN
        if (!sat) begin
            acc[0] = 10;
            acc[1] = -10;
        end
`endif
        for (int i = 0; i < d.size(); i++) begin
            for (int j = 0; j < NO; j++) begin
                w = sat ? 127 : ((j == 0) ? longint'(i + 1) : longint'(NI - i));
                acc[j] = acc[j] + w * d[i];
                if (acc[j] > hi) acc[j] = hi;
                if (acc[j] < lo) acc[j] = lo;
            end
        end
        cls = 0;
        sc  = acc[0];
        for (int j = 1; j < NO; j++) begin
            if (acc[j] > sc) begin
                cls = j;
                sc  = acc[j];
            end
        end
    endfunction

    task automatic run_frame(input longint d[$], input bit with_end, input int inject_k,
                             output int lat, output int cls_o, output longint sc_o);
        for (int i = 0; i < d.size(); i++) begin
            ce      = 1'b1;
            data_in = DW'(d[i]);
            end_in  = with_end && (i == d.size() - 1);
            @(posedge clk); #1;
        end
        ce = 1'b0; end_in = 1'b0; data_in = '0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (result_valid) begin
                lat = k;
                break;
            end
            ce      = (inject_k != 0) && (k == inject_k);
            data_in = ce ? DW'(1000) : '0;
        end
        ce = 1'b0; data_in = '0;
        cls_o = int'(class_id);
        sc_o  = longint'(score);
    endtask

    task automatic run_sat_frame(input longint d[$], output int lat, output int cls_o, output longint sc_o);
        for (int i = 0; i < d.size(); i++) begin
            s_ce      = 1'b1;
            s_data_in = DW'(d[i]);
            s_end_in  = (i == d.size() - 1);
            @(posedge clk); #1;
        end
        s_ce = 1'b0; s_end_in = 1'b0; s_data_in = '0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (s_result_valid) begin
                lat = k;
                break;
            end
        end
        cls_o = int'(s_class_id);
        sc_o  = longint'(s_score);
    endtask

    task automatic test_reset();
        n_checks++;
        if ({busy, result_valid, class_id, len_err, drop_err} !== 5'b0 || score !== '0) begin
            n_errors++;
            $display("FAIL reset_main: busy=%b rv=%b cls=%0d len=%b drop=%b score=%0d, want all 0",
                     busy, result_valid, class_id, len_err, drop_err, score);
        end
        n_checks++;
        if ({s_busy, s_result_valid, s_class_id, s_len_err, s_drop_err} !== 5'b0 || s_score !== '0) begin
            n_errors++;
            $display("FAIL reset_sat: busy=%b rv=%b score=%0d, want all 0", s_busy, s_result_valid, s_score);
        end
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        longint d[$];
        int lat, cls, ecls;
        longint sc, esc;
        d = '{1, 1, 1, 2};
        model(1'b0, d, ecls, esc);
        run_frame(d, 1'b1, 0, lat, cls, sc);
        n_checks++;
        if (lat !== 5) begin n_errors++; $display("FAIL basic_latency: got %0d want 5", lat); end
        n_checks++;
`ifdef FC_BIAS_EN
        if (cls !== 0 || sc !== 24) begin n_errors++; $display("FAIL basic_result: got %0d/%0d want 0/24", cls, sc); end
`else
        if (cls !== 0 || sc !== 14) begin n_errors++; $display("FAIL basic_result: got %0d/%0d want 0/14", cls, sc); end
`endif
        @(posedge clk); #1;
        n_checks++;
        if (result_valid !== 1'b0 || score !== AW'(esc) || int'(class_id) !== ecls || len_err !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_hold: rv=%b score=%0d len=%b want rv=0 score=%0d len=0", result_valid, score, len_err, esc);
        end
    endtask

    task automatic test_class_tie();
        longint d[$];
        int lat, cls, ecls;
        longint sc, esc;
        d = '{2, 0, 0, 0};
        model(1'b0, d, ecls, esc);
        run_frame(d, 1'b1, 0, lat, cls, sc);
        n_checks++;
        if (cls !== ecls || sc !== esc || lat !== 5) begin
            n_errors++;
            $display("FAIL class1: got %0d/%0d lat %0d want %0d/%0d lat 5", cls, sc, lat, ecls, esc);
        end
        d = '{1, 1, 1, 1};
        model(1'b0, d, ecls, esc);
        run_frame(d, 1'b0, 0, lat, cls, sc);
        n_checks++;
        if (cls !== ecls || sc !== esc || lat !== 5 || len_err !== 1'b0) begin
            n_errors++;
            $display("FAIL tie_noend: got %0d/%0d lat %0d len %b want %0d/%0d lat 5 len 0", cls, sc, lat, len_err, ecls, esc);
        end
    endtask

    task automatic test_random();
        longint d[$];
        logic signed [DW-1:0] v;
        int lat, cls, ecls;
        longint sc, esc;
        for (int f = 0; f < 8; f++) begin
            d.delete();
            for (int i = 0; i < NI; i++) begin
                v = DW'($urandom);
                d.push_back(longint'(v));
            end
            model(1'b0, d, ecls, esc);
            run_frame(d, 1'b1, 0, lat, cls, sc);
            n_checks++;
            if (cls !== ecls || sc !== esc || lat !== 5) begin
                n_errors++;
                $display("FAIL random_%0d: got %0d/%0d lat %0d want %0d/%0d lat 5", f, cls, sc, lat, ecls, esc);
            end
        end
    endtask

    task automatic test_len_err();
        longint d[$];
        int lat, cls, ecls;
        longint sc, esc;
        d = '{1, 1};
        model(1'b0, d, ecls, esc);
        run_frame(d, 1'b1, 0, lat, cls, sc);
        n_checks++;
        if (cls !== ecls || sc !== esc || lat !== 5 || len_err !== 1'b1) begin
            n_errors++;
            $display("FAIL early_end: got %0d/%0d lat %0d len %b want %0d/%0d lat 5 len 1", cls, sc, lat, len_err, ecls, esc);
        end
    endtask

    task automatic test_drop();
        longint d[$];
        int lat, cls, ecls;
        longint sc, esc;
        n_checks++;
        if (drop_err !== 1'b0) begin n_errors++; $display("FAIL drop_pre: got %b want 0", drop_err); end
        d = '{1, 1, 1, 2};
        model(1'b0, d, ecls, esc);
        run_frame(d, 1'b1, 2, lat, cls, sc);
        n_checks++;
        if (cls !== ecls || sc !== esc || lat !== 5 || drop_err !== 1'b1) begin
            n_errors++;
            $display("FAIL drop_argmax: got %0d/%0d lat %0d drop %b want %0d/%0d lat 5 drop 1", cls, sc, lat, drop_err, ecls, esc);
        end
        d = '{2, 0, 0, 0};
        model(1'b0, d, ecls, esc);
        run_frame(d, 1'b1, 0, lat, cls, sc);
        n_checks++;
        if (cls !== ecls || sc !== esc || lat !== 5) begin
            n_errors++;
            $display("FAIL after_drop: got %0d/%0d lat %0d want %0d/%0d lat 5", cls, sc, lat, ecls, esc);
        end
    endtask

    task automatic test_mid_reset();
        longint d[$];
        int lat, cls, ecls;
        longint sc, esc;
        for (int i = 0; i < 2; i++) begin
            ce = 1'b1; data_in = DW'(300); end_in = 1'b0;
            @(posedge clk); #1;
        end
        ce = 1'b0; data_in = '0;
        n_checks++;
        if (busy !== 1'b1) begin n_errors++; $display("FAIL midframe_busy: got %b want 1", busy); end
        reset = 1'b0;
        #1;
        n_checks++;
        if ({busy, result_valid, class_id, len_err, drop_err} !== 5'b0 || score !== '0) begin
            n_errors++;
            $display("FAIL mid_reset: busy=%b cls=%0d len=%b drop=%b score=%0d want all 0", busy, class_id, len_err, drop_err, score);
        end
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        d = '{1, 1, 1, 2};
        model(1'b0, d, ecls, esc);
        run_frame(d, 1'b1, 0, lat, cls, sc);
        n_checks++;
        if (cls !== ecls || sc !== esc || lat !== 5) begin
            n_errors++;
            $display("FAIL post_reset_frame: got %0d/%0d lat %0d want %0d/%0d lat 5", cls, sc, lat, ecls, esc);
        end
    endtask

    task automatic test_saturation();
        longint d[$];
        logic signed [DW-1:0] v;
        int lat, cls, ecls;
        longint sc, esc;
        for (int f = 0; f < 7; f++) begin
            d.delete();
            case (f)
                0: d = '{524287, 524287, 524287, 524287};
                1: d = '{-524288, -524288, -524288, -524288};
                2: d = '{524287, 524287, -524288, -524288};
                default: begin
                    for (int i = 0; i < NI; i++) begin
                        v = DW'($urandom);
                        d.push_back(longint'(v));
                    end
                end
            endcase
            model(1'b1, d, ecls, esc);
            run_sat_frame(d, lat, cls, sc);
            n_checks++;
            if (cls !== ecls || sc !== esc || lat !== 5) begin
                n_errors++;
                $display("FAIL saturate_%0d: got %0d/%0d lat %0d want %0d/%0d lat 5", f, cls, sc, lat, ecls, esc);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        ce = 1'b0; end_in = 1'b0; data_in = '0;
        s_ce = 1'b0; s_end_in = 1'b0; s_data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_class_tie();
        test_random();
        test_len_err();
        test_drop();
        test_mid_reset();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
